blink_sequencer: RTL and testbench
==================================

# blink_sequencer

Pattern sequencer that sits directly upstream of the on/off period timer driving the board LEDs. It holds a small programmable table of (on, off) cycle counts and hands one entry at a time to the timer over a valid/ready handshake. It advances to the next entry when the timer reports a completed period, loops over the table a programmed number of times, then signals done.

## Interface
- `CNT_W`, 28: width of on/off cycle counts; matches the timer counter.
- `DEPTH`, 8: pattern table entries; power of two.
- `IDX_W`, $clog2(DEPTH): table index width (derived).

- `CLK100MHZ`  in  1  system clock, 100 MHz; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  IDX_W  table write address.
- `wr_on`, `wr_off`  in  CNT_W each  on/off cycle counts to write.
- `seq_len`  in  IDX_W+1  number of table entries used, starting at entry 0; sampled on start.
- `loops`  in  8  passes through the table; 0 = forever; sampled on start.
- `start`  in  1  single-cycle start request.
- `stop`  in  1  single-cycle abort request.
- `cfg_on`, `cfg_off`  out  CNT_W each  period presented to the timer.
- `cfg_valid`  out  1  cfg_on/cfg_off valid.
- `cfg_ready`  in  1  timer accepts cfg this cycle.
- `period_done`  in  1  single-cycle pulse from the timer when a full on+off period ends.
- `busy`  out  1  sequence in progress.
- `done`  out  1  single-cycle pulse when the sequence completes normally.
- `step_idx`  out  IDX_W  current table entry.

## Operation
- FSM states: IDLE, LOAD, RUN, FIN.
  - IDLE: `start` with `seq_len` ≠ 0 → LOAD at entry 0, latching `seq_len` and `loops`. `start` with `seq_len` = 0 → FIN.
  - LOAD: `cfg_valid` = 1. `cfg_on`/`cfg_off` hold the entry latched on entry to LOAD. When `cfg_valid` & `cfg_ready` → RUN.
  - RUN: on `period_done`, the step advances.
    - If not the last entry: `step_idx`+1, → LOAD.
    - If last entry and passes remain (or `loops` = 0): `step_idx` = 0, pass count +1, → LOAD.
    - Otherwise → FIN.
  - FIN: `done` = 1 for exactly one cycle, → IDLE.
- `stop` in LOAD/RUN/FIN → IDLE next cycle:
  - `cfg_valid` drops and `done` is not pulsed.
  - `stop` wins over a simultaneous `period_done` or handshake.
  - `stop` in IDLE is ignored.
- `start` outside IDLE is ignored. `start` and `stop` together in IDLE: `stop` wins, and the block stays in IDLE.
- Table writes:
  - Accepted in any state; synchronous write.
  - A write to the entry currently presented does not change `cfg_on`/`cfg_off`, because they are latched. The new value is used on the next fetch of that entry.
- `seq_len` > DEPTH is clamped to DEPTH at sampling.
- Pass counter is 8 bits. With `loops` = N, exactly N×`seq_len` periods run. With `loops` = 0 the counter is not compared and never causes completion.
- Zero on/off entries are passed through unchanged; the timer owns their interpretation.
- `period_done` outside RUN is ignored.
- `busy` = 1 in LOAD, RUN and FIN.

## Timing
- Reset values: state IDLE, `cfg_on` = `cfg_off` = 0, `cfg_valid` = 0, `busy` = 0, `done` = 0, `step_idx` = 0, pass count 0. The table is not cleared.
- `start` at cycle t → `cfg_valid` = 1 with entry 0 at t+1.
- The handshake completes in the cycle where `cfg_valid` & `cfg_ready` are both high. `cfg_valid` is 0 at the next cycle.
- `period_done` at t:
  - Next entry presented with `cfg_valid` = 1 at t+1.
  - On the final period, `done` = 1 at t+1 and `busy` = 0 at t+2.
- `stop` at t → `cfg_valid` = 0 and `busy` = 0 at t+1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `blink_pkg`:
  - state enum (IDLE/LOAD/RUN/FIN);
  - default `CNT_W` = 28 and `DEPTH` = 8;
  - the `{on, off}` entry struct type, shared with the timer.
- Sub-module `blink_pattern_ram`: DEPTH × 2·CNT_W, synchronous write, asynchronous read. The sequencer latches the read data into `cfg_on`/`cfg_off` on entry to LOAD.

## Test plan
- Write entries 0:(100,200), 1:(50,50); `seq_len` = 2, `loops` = 1; `start`; `cfg_ready` tied 1; `period_done` pulsed per accepted cfg → cfg sequence (100,200), (50,50); `done` pulses once, 1 cycle after the 2nd `period_done`; `busy` low the cycle after.
- `loops` = 3, `seq_len` = 2 → exactly 6 handshakes, with `step_idx` 0,1,0,1,0,1, then `done`.
- `cfg_ready` held low 10 cycles → `cfg_valid` and cfg values stable for all 10 cycles; `period_done` pulses during that window are ignored.
- `stop` in the same cycle as `period_done` in RUN → IDLE next cycle, `cfg_valid` = 0, no `done`, no new cfg.
- `seq_len` = 0 `start` → `done` at t+2 with no `cfg_valid`. `start` while busy → no effect. `reset` mid-RUN → all outputs at reset values next cycle, and table contents preserved.
- Rewrite entry 0 while entry 0 is presented → presented value unchanged; the new value appears on the next pass.

Source files
------------

// File: rtl/blink_pkg.sv
`default_nettype none
// blink_pkg: shared state encoding, default widths and table entry type
// for the blink sequencer and its period timer.  Rev 1.0
package blink_pkg;

   localparam int BLINK_CNT_W = 28;
   localparam int BLINK_DEPTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      FIN  = 2'd3
   } blink_state_e;

   typedef struct packed {
      logic [BLINK_CNT_W-1:0] on;
      logic [BLINK_CNT_W-1:0] off;
   } blink_entry_t;

endpackage
`default_nettype wire

// File: rtl/blink_pattern_ram.sv
`default_nettype none
// blink_pattern_ram: DEPTH x W pattern table, synchronous write,
// asynchronous read.  Rev 1.0
module blink_pattern_ram
   import blink_pkg::*;
#(
   parameter int W     = 2 * BLINK_CNT_W,
   parameter int DEPTH = BLINK_DEPTH,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic [W-1:0]     wr_data,
   input  logic [IDX_W-1:0] rd_addr,
   output logic [W-1:0]     rd_data
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/blink_sequencer.sv
`default_nettype none
// blink_sequencer: steps through a programmable (on, off) table, handing each
// entry to the LED period timer over valid/ready.  Rev 1.0
module blink_sequencer
   import blink_pkg::*;
#(
   parameter int CNT_W = BLINK_CNT_W,
   parameter int DEPTH = BLINK_DEPTH,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             CLK100MHZ,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic [CNT_W-1:0] wr_on,
   input  logic [CNT_W-1:0] wr_off,
   input  logic [IDX_W:0]   seq_len,
   input  logic [7:0]       loops,
   input  logic             start,
   input  logic             stop,
   output logic [CNT_W-1:0] cfg_on,
   output logic [CNT_W-1:0] cfg_off,
   output logic             cfg_valid,
   input  logic             cfg_ready,
   input  logic             period_done,
   output logic             busy,
   output logic             done,
   output logic [IDX_W-1:0] step_idx
);

   localparam int LEN_W = IDX_W + 1;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);

   blink_state_e     state;
   logic [LEN_W-1:0] len_r;
   logic [7:0]       loops_r;
   logic [7:0]       pass_cnt;
   logic [IDX_W-1:0] fetch_idx;
   logic [2*CNT_W-1:0] rd_data;
   logic [CNT_W-1:0] rd_on;
   logic [CNT_W-1:0] rd_off;
   logic             last_step;
   logic             more_passes;

   blink_pattern_ram #(
      .W     (2 * CNT_W),
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_ram (
      .clk     (CLK100MHZ),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data ({wr_on, wr_off}),
      .rd_addr (fetch_idx),
      .rd_data (rd_data)
   );

   assign {rd_on, rd_off} = rd_data;

   assign last_step   = ({1'b0, step_idx} == (len_r - 1'b1));
   // pass_cnt never exceeds loops_r - 1, so the 8-bit increment cannot wrap here.
   assign more_passes = (loops_r == 8'd0) || ((pass_cnt + 8'd1) != loops_r);

   // Address of the entry fetched on the next transition into LOAD.
   assign fetch_idx = (state == RUN && !last_step) ? step_idx + 1'b1 : '0;

   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         state     <= IDLE;
         cfg_on    <= '0;
         cfg_off   <= '0;
         cfg_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         step_idx  <= '0;
         pass_cnt  <= '0;
         len_r     <= '0;
         loops_r   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start && !stop) begin
                  len_r   <= (seq_len > MAX_LEN) ? MAX_LEN : seq_len;
                  loops_r <= loops;
                  busy    <= 1'b1;
                  if (seq_len == '0) begin
                     state <= FIN;
                  end else begin
                     state     <= LOAD;
                     step_idx  <= '0;
                     pass_cnt  <= '0;
                     cfg_on    <= rd_on;
                     cfg_off   <= rd_off;
                     cfg_valid <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (stop) begin
                  state     <= IDLE;
                  cfg_valid <= 1'b0;
                  busy      <= 1'b0;
               end else if (cfg_ready) begin
                  state     <= RUN;
                  cfg_valid <= 1'b0;
               end
            end
            RUN: begin
               if (stop) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (period_done) begin
                  if (!last_step || more_passes) begin
                     state     <= LOAD;
                     step_idx  <= fetch_idx;
                     cfg_on    <= rd_on;
                     cfg_off   <= rd_off;
                     cfg_valid <= 1'b1;
                     if (last_step) begin
                        pass_cnt <= pass_cnt + 8'd1;
                     end
                  end else begin
                     state <= FIN;
                     done  <= 1'b1;
                  end
               end
            end
            FIN: begin
               // A zero-length start enters FIN with done low; it pulses one cycle later.
               if (stop || done) begin
                  state <= IDLE;
                  done  <= 1'b0;
                  busy  <= 1'b0;
               end else begin
                  done <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_blink_sequencer.sv
`default_nettype none
// tb_blink_sequencer: randomized and directed checks of blink_sequencer against
// an expected-entry-list model built from the table contents.  Rev 1.0
module tb_blink_sequencer;

   localparam int CNT_W = 28;
   localparam int DEPTH = 8;
   localparam int IDX_W = 3;

   logic             CLK100MHZ = 1'b0;
   logic             reset = 1'b1;
   logic             wr_en = 1'b0;
   logic [IDX_W-1:0] wr_addr = '0;
   logic [CNT_W-1:0] wr_on = '0;
   logic [CNT_W-1:0] wr_off = '0;
   logic [IDX_W:0]   seq_len = '0;
   logic [7:0]       loops = '0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic [CNT_W-1:0] cfg_on;
   logic [CNT_W-1:0] cfg_off;
   logic             cfg_valid;
   logic             cfg_ready = 1'b0;
   logic             period_done = 1'b0;
   logic             busy;
   logic             done;
   logic [IDX_W-1:0] step_idx;

   int n_checks = 0;
   int n_errors = 0;

   logic [CNT_W-1:0] tbl_on  [DEPTH];
   logic [CNT_W-1:0] tbl_off [DEPTH];

   blink_sequencer #(.CNT_W(CNT_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
      .CLK100MHZ   (CLK100MHZ),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_on       (wr_on),
      .wr_off      (wr_off),
      .seq_len     (seq_len),
      .loops       (loops),
      .start       (start),
      .stop        (stop),
      .cfg_on      (cfg_on),
      .cfg_off     (cfg_off),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .period_done (period_done),
      .busy        (busy),
      .done        (done),
      .step_idx    (step_idx)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK100MHZ);
      #1;
   endtask

   task automatic wr(input int a, input logic [CNT_W-1:0] on_v, input logic [CNT_W-1:0] off_v);
      wr_en   = 1'b1;
      wr_addr = IDX_W'(a);
      wr_on   = on_v;
      wr_off  = off_v;
      step();
      wr_en = 1'b0;
      tbl_on[a]  = on_v;
      tbl_off[a] = off_v;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_on"},    64'(cfg_on), 0);
      check({tag, "_off"},   64'(cfg_off), 0);
      check({tag, "_valid"}, 64'(cfg_valid), 0);
      check({tag, "_busy"},  64'(busy), 0);
      check({tag, "_done"},  64'(done), 0);
      check({tag, "_idx"},   64'(step_idx), 0);
   endtask

   task automatic check_presented(input string tag, input int i);
      check({tag, "_valid"}, 64'(cfg_valid), 1);
      check({tag, "_on"},    64'(cfg_on), 64'(tbl_on[i]));
      check({tag, "_off"},   64'(cfg_off), 64'(tbl_off[i]));
      check({tag, "_idx"},   64'(step_idx), 64'(i));
   endtask

   // Model: the run is the table prefix of length min(len, DEPTH), repeated lp times.
   task automatic run_seq(input int len, input int lp);
      int eff;
      int i;
      int idx_q[$];
      eff = (len > DEPTH) ? DEPTH : len;
      for (int p = 0; p < lp; p++)
         for (int e = 0; e < eff; e++)
            idx_q.push_back(e);
      seq_len = (IDX_W+1)'(len);
      loops   = 8'(lp);
      start   = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < idx_q.size(); k++) begin
         i = idx_q[k];
         check_presented("seq", i);
         check("seq_done_lo", 64'(done), 0);
         cfg_ready = 1'b0;
         repeat ($urandom_range(0, 3)) begin
            step();
            check_presented("hold", i);
         end
         cfg_ready = 1'b1;
         step();
         cfg_ready = 1'b0;
         check("acc_valid", 64'(cfg_valid), 0);
         check("acc_busy", 64'(busy), 1);
         repeat ($urandom_range(0, 3)) step();
         period_done = 1'b1;
         step();
         period_done = 1'b0;
      end
      check("fin_done", 64'(done), 1);
      check("fin_busy", 64'(busy), 1);
      check("fin_valid", 64'(cfg_valid), 0);
      step();
      check("end_done", 64'(done), 0);
      check("end_busy", 64'(busy), 0);
   endtask

   initial begin
      repeat (3) step();
      check_reset_vals("rst");
      reset = 1'b0;
      step();
      check_reset_vals("post_rst");

      // Basic two-entry single pass, then three passes.
      wr(0, 28'd100, 28'd200);
      wr(1, 28'd50, 28'd50);
      run_seq(2, 1);
      run_seq(2, 3);

      // Randomized tables, lengths (including clamp) and pass counts.
      for (int it = 0; it < 6; it++) begin
         for (int a = 0; a < DEPTH; a++) begin
            if ($urandom_range(0, 7) == 0) wr(a, '0, CNT_W'($urandom));
            else wr(a, CNT_W'($urandom), CNT_W'($urandom));
         end
         run_seq($urandom_range(1, 10), $urandom_range(1, 3));
      end

      // Ready held low: cfg stays stable, period_done ignored outside RUN.
      seq_len = 4'd2; loops = 8'd1; start = 1'b1;
      step();
      start = 1'b0;
      for (int j = 0; j < 10; j++) begin
         period_done = j[0];
         step();
         check_presented("nordy", 0);
      end
      period_done = 1'b0;
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("nordy_stop_valid", 64'(cfg_valid), 0);
      check("nordy_stop_busy", 64'(busy), 0);

      // stop together with period_done in RUN.
      start = 1'b1;
      step();
      start = 1'b0;
      cfg_ready = 1'b1;
      step();
      cfg_ready = 1'b0;
      stop = 1'b1; period_done = 1'b1;
      step();
      stop = 1'b0; period_done = 1'b0;
      check("stop_valid", 64'(cfg_valid), 0);
      check("stop_busy", 64'(busy), 0);
      check("stop_done", 64'(done), 0);
      step();
      check("stop2_valid", 64'(cfg_valid), 0);
      check("stop2_done", 64'(done), 0);

      // Zero-length start: done two cycles later, never valid.
      seq_len = '0; start = 1'b1;
      step();
      start = 1'b0;
      check("z1_valid", 64'(cfg_valid), 0);
      check("z1_done", 64'(done), 0);
      step();
      check("z2_valid", 64'(cfg_valid), 0);
      check("z2_done", 64'(done), 1);
      step();
      check("z3_done", 64'(done), 0);
      check("z3_busy", 64'(busy), 0);

      // start and stop together in IDLE; stop alone in IDLE.
      seq_len = 4'd2; start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      check("ss_busy", 64'(busy), 0);
      check("ss_valid", 64'(cfg_valid), 0);

      // start while busy is ignored: the original length of 2 still runs.
      seq_len = 4'd2; loops = 8'd1; start = 1'b1;
      step();
      seq_len = 4'd1; loops = 8'd5;
      step();
      start = 1'b0;
      check_presented("sb0", 0);
      cfg_ready = 1'b1; step(); cfg_ready = 1'b0;
      period_done = 1'b1; step(); period_done = 1'b0;
      check_presented("sb1", 1);
      check("sb1_done", 64'(done), 0);
      cfg_ready = 1'b1; step(); cfg_ready = 1'b0;
      period_done = 1'b1; step(); period_done = 1'b0;
      check("sb_done", 64'(done), 1);
      step();

      // Reset mid-RUN returns reset values and keeps the table.
      seq_len = 4'd3; loops = 8'd2; start = 1'b1;
      step();
      start = 1'b0;
      cfg_ready = 1'b1; step(); cfg_ready = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_reset_vals("midrst");
      run_seq(3, 1);

      // Rewrite entry 0 while it is presented.
      wr(0, 28'd11, 28'd22);
      wr(1, 28'd33, 28'd44);
      seq_len = 4'd2; loops = 8'd2; start = 1'b1;
      step();
      start = 1'b0;
      wr(0, 28'd555, 28'd666);
      check("rw_on_old", 64'(cfg_on), 64'd11);
      check("rw_off_old", 64'(cfg_off), 64'd22);
      for (int k = 0; k < 4; k++) begin
         if (k != 0) check_presented("rw", k % 2);
         cfg_ready = 1'b1; step(); cfg_ready = 1'b0;
         period_done = 1'b1; step(); period_done = 1'b0;
      end
      check("rw_done", 64'(done), 1);
      step();
      check("rw_busy", 64'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
